burst_rx_checker: RTL and testbench



---
 rtl/burst_rx_checker.sv | 198 +++++++++++++++++++
 tb/tb_burst_rx_checker.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/burst_rx_checker.sv
// Receive-side checker for PRBS-31 bursts: validates preamble/delimiter framing,
// compares payload against a self-seeded reference and keeps saturating status counters.

module burst_rx_sat_cnt #(
    parameter int CNT_W = 32,
    parameter int ADD_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [ADD_W-1:0] add,
    output logic [CNT_W-1:0] cnt
);
    logic [CNT_W:0] sum;

    assign sum = {1'b0, cnt} + {{(CNT_W + 1 - ADD_W){1'b0}}, add};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           cnt <= '0;
        else if (clear)       cnt <= '0;
        else if (sum[CNT_W])  cnt <= '1;
        else                  cnt <= sum[CNT_W-1:0];
    end
endmodule

module burst_rx_checker #(
    parameter logic [31:0] PREAMBLE  = 32'h05560556,
    parameter logic [31:0] DELIMITER = 32'hB2C50FA1,
    parameter int          CNT_W     = 32
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic [31:0]      s_axis_tdata,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tlast,
    input  logic [3:0]       s_axis_tkeep,
    output logic             s_axis_tready,
    input  logic [31:0]      min_preamble,
    input  logic [31:0]      burst_length,
    input  logic             clear_counters,
    output logic             locked,
    output logic             burst_done,
    output logic [CNT_W-1:0] burst_cnt,
    output logic [CNT_W-1:0] word_err_cnt,
    output logic [CNT_W-1:0] bit_err_cnt,
    output logic [CNT_W-1:0] frame_err_cnt,
    output logic [CNT_W-1:0] len_err_cnt
);
    typedef enum logic [1:0] {IDLE, PRE, PAY} state_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [3:0]  keep;
    } beat_t;

    localparam int NUM_CNT = 5;
    localparam int ADD_W   = 6;
    localparam int C_BURST = 0;
    localparam int C_WORD  = 1;
    localparam int C_BIT   = 2;
    localparam int C_FRAME = 3;
    localparam int C_LEN   = 4;

    // Next 32 stream bits of x^31+x^28+1; bit 31 of a word is the oldest bit.
    function automatic logic [31:0] prbs_next(input logic [31:0] w);
        logic [63:0] s;
        logic [31:0] r;
        s = '0;
        for (int i = 0; i < 32; i++) s[i] = w[31-i];
        for (int i = 32; i < 64; i++) s[i] = s[i-31] ^ s[i-28];
        for (int j = 0; j < 32; j++) r[31-j] = s[32+j];
        return r;
    endfunction

    function automatic logic [ADD_W-1:0] popcount(input logic [31:0] v);
        logic [ADD_W-1:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) c = c + {{(ADD_W-1){1'b0}}, v[i]};
        return c;
    endfunction

    state_t      state, state_nxt;
    beat_t       beat;
    logic        xfer;
    logic [31:0] pre_cnt, pay_cnt, ref_q, diff;
    logic        seed_pending;
    logic        to_pre, pre_inc, to_pay, pay_word, pay_end, frame_fsm, cmp;

    logic [NUM_CNT-1:0][ADD_W-1:0] cnt_add;
    logic [NUM_CNT-1:0][CNT_W-1:0] cnt_q;

    assign beat   = '{data: s_axis_tdata, last: s_axis_tlast, keep: s_axis_tkeep};
    assign xfer   = s_axis_tvalid & s_axis_tready;
    assign locked = (state == PAY);
    assign diff   = beat.data ^ ref_q;
    assign cmp    = pay_word & ~seed_pending;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state         <= IDLE;
            s_axis_tready <= 1'b0;
        end else begin
            state         <= state_nxt;
            s_axis_tready <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        to_pre    = 1'b0;
        pre_inc   = 1'b0;
        to_pay    = 1'b0;
        pay_word  = 1'b0;
        pay_end   = 1'b0;
        frame_fsm = 1'b0;
        if (xfer) begin
            unique case (state)
                IDLE: begin
                    if (beat.last) begin
                        frame_fsm = 1'b1;
                    end else if (beat.data == PREAMBLE) begin
                        to_pre    = 1'b1;
                        state_nxt = PRE;
                    end
                end
                PRE: begin
                    if (!beat.last && beat.data == PREAMBLE) begin
                        pre_inc = 1'b1;
                    end else if (!beat.last && beat.data == DELIMITER &&
                                 pre_cnt >= min_preamble) begin
                        to_pay    = 1'b1;
                        state_nxt = PAY;
                    end else begin
                        frame_fsm = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                PAY: begin
                    pay_word = 1'b1;
                    if (beat.last) begin
                        pay_end   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // First payload word seeds the reference; after that it free-runs.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            pre_cnt      <= '0;
            pay_cnt      <= '0;
            seed_pending <= 1'b0;
            ref_q        <= '0;
            burst_done   <= 1'b0;
        end else begin
            burst_done <= pay_end;
            if (to_pre)                       pre_cnt <= 32'd1;
            else if (pre_inc && pre_cnt != '1) pre_cnt <= pre_cnt + 32'd1;
            if (to_pay) begin
                pay_cnt      <= '0;
                seed_pending <= 1'b1;
            end else if (pay_word) begin
                pay_cnt      <= pay_cnt + 32'd1;
                seed_pending <= 1'b0;
                ref_q        <= seed_pending ? prbs_next(beat.data) : prbs_next(ref_q);
            end
        end
    end

    always_comb begin
        cnt_add          = '0;
        cnt_add[C_BURST] = {{(ADD_W-1){1'b0}}, pay_end};
        cnt_add[C_WORD]  = {{(ADD_W-1){1'b0}}, cmp & (|diff)};
        cnt_add[C_BIT]   = cmp ? popcount(diff) : '0;
        cnt_add[C_FRAME] = {{(ADD_W-1){1'b0}}, (xfer && beat.keep != 4'hF) || frame_fsm};
        cnt_add[C_LEN]   = {{(ADD_W-1){1'b0}}, pay_end && ((pay_cnt + 32'd1) != burst_length)};
    end

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        burst_rx_sat_cnt #(.CNT_W(CNT_W), .ADD_W(ADD_W)) u_cnt (
            .clk   (ap_clk),
            .rst_n (ap_rst_n),
            .clear (clear_counters),
            .add   (cnt_add[g]),
            .cnt   (cnt_q[g])
        );
    end

    assign burst_cnt     = cnt_q[C_BURST];
    assign word_err_cnt  = cnt_q[C_WORD];
    assign bit_err_cnt   = cnt_q[C_BIT];
    assign frame_err_cnt = cnt_q[C_FRAME];
    assign len_err_cnt   = cnt_q[C_LEN];
endmodule

// File: tb/tb_burst_rx_checker.sv
// Directed bench for burst_rx_checker: a serial PRBS-31 model builds bursts and a
// scoreboard of expected counter snapshots is checked on every burst_done pulse.

module tb_burst_rx_checker;
    localparam logic [31:0] PREAMBLE  = 32'h05560556;
    localparam logic [31:0] DELIMITER = 32'hB2C50FA1;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic [3:0]  s_axis_tkeep;
    logic [31:0] min_preamble, burst_length;
    logic        clear_counters, locked, burst_done;
    logic [31:0] burst_cnt, word_err_cnt, bit_err_cnt, frame_err_cnt, len_err_cnt;

    typedef struct {
        logic [31:0] bc, we, be, fe, le;
    } snap_t;

    snap_t       sb[$];
    snap_t       got_snap;
    int          ncmp = 0, nerr = 0, lock_total = 0;
    bit          gap_en = 0;
    logic [30:0] hist;
    logic [31:0] m_bc, m_we, m_be, m_fe, m_le;

    burst_rx_checker dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tready(s_axis_tready),
        .min_preamble(min_preamble), .burst_length(burst_length),
        .clear_counters(clear_counters), .locked(locked), .burst_done(burst_done),
        .burst_cnt(burst_cnt), .word_err_cnt(word_err_cnt), .bit_err_cnt(bit_err_cnt),
        .frame_err_cnt(frame_err_cnt), .len_err_cnt(len_err_cnt)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Serial stream model: b[k] = b[k-31] ^ b[k-28]; hist[0] is the newest bit.
    function automatic logic [31:0] gen_word();
        logic [31:0] w;
        logic        b;
        for (int j = 0; j < 32; j++) begin
            b        = hist[30] ^ hist[27];
            hist     = {hist[29:0], b};
            w[31-j]  = b;
        end
        return w;
    endfunction

    function automatic logic [31:0] ones(input logic [31:0] v);
        logic [31:0] c = 0;
        for (int i = 0; i < 32; i++) c += {31'd0, v[i]};
        return c;
    endfunction

    // Inputs stay stable across the sampling edge; locked&tvalid at negedge is a payload xfer.
    always @(negedge ap_clk) begin
        if (locked && s_axis_tvalid) lock_total++;
        if (ap_rst_n && burst_done) begin
            if (sb.size() == 0) begin
                check("burst_done_unexpected", 32'd1, 32'd0);
            end else begin
                got_snap = sb.pop_front();
                check("sb_burst_cnt",     burst_cnt,     got_snap.bc);
                check("sb_word_err_cnt",  word_err_cnt,  got_snap.we);
                check("sb_bit_err_cnt",   bit_err_cnt,   got_snap.be);
                check("sb_frame_err_cnt", frame_err_cnt, got_snap.fe);
                check("sb_len_err_cnt",   len_err_cnt,   got_snap.le);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge ap_clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic l, input logic [3:0] k, input logic clr);
        if (gap_en) while ($urandom_range(0, 9) < 3) idle(1);
        s_axis_tdata   = d;
        s_axis_tlast   = l;
        s_axis_tkeep   = k;
        s_axis_tvalid  = 1'b1;
        clear_counters = clr;
        idle(1);
        s_axis_tvalid  = 1'b0;
        s_axis_tlast   = 1'b0;
        s_axis_tkeep   = 4'hF;
        clear_counters = 1'b0;
    endtask

    task automatic zero_model();
        m_bc = 0; m_we = 0; m_be = 0; m_fe = 0; m_le = 0;
    endtask

    // err_idx/keep_idx of -1 disable the corresponding fault.
    task automatic burst(input int npre, input int npay, input int err_idx,
                         input logic [31:0] err_mask, input int keep_idx, input bit clr_last);
        int          lock0;
        logic [31:0] w;
        bit          last;
        lock0 = lock_total;
        for (int i = 0; i < npre; i++) begin
            if (i == keep_idx) m_fe++;
            send(PREAMBLE, 1'b0, (i == keep_idx) ? 4'h7 : 4'hF, 1'b0);
        end
        send(DELIMITER, 1'b0, 4'hF, 1'b0);
        if (npre < int'(min_preamble)) begin
            m_fe++;
            return;
        end
        hist = 31'($urandom) | 31'd1;
        for (int j = 0; j < npay; j++) begin
            w    = gen_word();
            last = (j == npay - 1);
            if (j == err_idx) begin
                w = w ^ err_mask;
                if (j > 0) begin
                    m_we++;
                    m_be += ones(err_mask);
                end
            end
            if (last) begin
                m_bc++;
                if (npay != int'(burst_length)) m_le++;
                if (clr_last) zero_model();
                sb.push_back('{m_bc, m_we, m_be, m_fe, m_le});
            end
            send(w, last, 4'hF, clr_last && last);
        end
        idle(2);
        check("locked_xfers", 32'(lock_total - lock0), 32'(npay));
    endtask

    task automatic check_all(input string tag);
        check({tag, "_burst"}, burst_cnt,     m_bc);
        check({tag, "_word"},  word_err_cnt,  m_we);
        check({tag, "_bit"},   bit_err_cnt,   m_be);
        check({tag, "_frame"}, frame_err_cnt, m_fe);
        check({tag, "_len"},   len_err_cnt,   m_le);
    endtask

    initial begin
        ap_rst_n       = 1'b0;
        s_axis_tdata   = '0;
        s_axis_tvalid  = 1'b0;
        s_axis_tlast   = 1'b0;
        s_axis_tkeep   = 4'hF;
        clear_counters = 1'b0;
        min_preamble   = 32'd4;
        burst_length   = 32'd64;
        zero_model();
        idle(3);
        check("rst_tready", {31'd0, s_axis_tready}, 32'd0);
        check("rst_locked", {31'd0, locked}, 32'd0);
        check_all("rst");
        ap_rst_n = 1'b1;
        check("rel_tready_same", {31'd0, s_axis_tready}, 32'd0);
        idle(1);
        check("rel_tready_next", {31'd0, s_axis_tready}, 32'd1);

        // clean burst
        burst(8, 64, -1, 0, -1, 0);
        check_all("clean");

        // single corrupted word; the following word must not count
        burst(8, 64, 10, 32'h0000_0101, -1, 0);
        check_all("corrupt");

        // too few preamble words, then a good burst
        burst(2, 0, -1, 0, -1, 0);
        check("short_pre_frame", frame_err_cnt, m_fe);
        check("short_pre_locked", {31'd0, locked}, 32'd0);
        burst(6, 64, -1, 0, -1, 0);
        check_all("after_short");

        // short payload
        burst(8, 50, -1, 0, -1, 0);
        check_all("short_pay");

        // keep error inside preamble, tlast seen in IDLE
        burst(5, 64, -1, 0, 2, 0);
        send(32'h1234_5678, 1'b1, 4'hF, 1'b0);
        m_fe++;
        check_all("keep_idle_last");

        // 100 bursts with gaps; clear coincides with one burst_cnt increment
        gap_en = 1;
        for (int b = 0; b < 100; b++)
            burst($urandom_range(4, 8), 64, -1, 0, -1, (b == 50));
        gap_en = 0;
        check_all("random");

        // reset in the middle of a payload
        for (int i = 0; i < 8; i++) send(PREAMBLE, 1'b0, 4'hF, 1'b0);
        send(DELIMITER, 1'b0, 4'hF, 1'b0);
        hist = 31'h1ACE_55A3;
        for (int j = 0; j < 20; j++) send(gen_word(), 1'b0, 4'hF, 1'b0);
        check("midrst_locked_before", {31'd0, locked}, 32'd1);
        ap_rst_n = 1'b0;
        zero_model();
        #1;
        check_all("midrst");
        idle(3);
        check("midrst_tready", {31'd0, s_axis_tready}, 32'd0);
        check("midrst_locked", {31'd0, locked}, 32'd0);
        ap_rst_n = 1'b1;
        idle(1);
        check("midrst_tready_rel", {31'd0, s_axis_tready}, 32'd1);
        burst(8, 64, -1, 0, -1, 0);
        check_all("post_rst");

        idle(5);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
